data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the single-cycle MIPS core's data port. Consumes pc/memwrite/aluout/writedata and returns readdata.
- Contains a word-addressed data RAM plus a small memory-mapped register page: LED register, cycle counter, store counter, status.
- Detects the lab "pass" store and flags misaligned stores. It sits beside the instruction ROM in the top level.

Parameters:
- DEPTH_LOG2, 6, log2 of RAM depth in 32-bit words (default 64 words).
- MMIO_BASE, 32'hFFFF_FF00, base byte address of the 16-byte register page.
- DONE_ADDR, 32'd84, byte address of the pass-check store.
- DONE_DATA, 32'd7, data value that marks pass.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- memwrite  input  1  store enable from core
- aluout  input  32  byte address from core
- writedata  input  32  store data from core
- readdata  output  32  load data to core, combinational
- led  output  32  LED register value
- done  output  1  sticky pass flag
- align_err  output  1  sticky misaligned-store flag

Behaviour:
- Reset (synchronous, active-high):
  - led=0, cycle_cnt=0, store_cnt=0, done=0, align_err=0.
  - RAM contents are not cleared.
  - While rst=1 all stores are ignored and no counters advance.
  - Reset asserted mid-run clears all registers at that edge; the store presented in that cycle is dropped.
- Address decode:
  - mmio_hit = (aluout[31:4] == MMIO_BASE[31:4]).
  - Otherwise the access is a RAM access with index aluout[DEPTH_LOG2+1:2]. Upper bits are ignored, so addresses alias modulo 4*2^DEPTH_LOG2 bytes.
- Reads (combinational, zero latency; readdata is valid every cycle regardless of memwrite):
  - RAM: readdata = ram[index].
  - MMIO offset 0x0: led.
  - MMIO offset 0x4: cycle_cnt.
  - MMIO offset 0x8: store_cnt.
  - MMIO offset 0xC: {30'b0, align_err, done}.
  - Read-during-write: readdata shows the pre-write value; the new value is visible from the next cycle.
- Stores (memwrite=1, rst=0, at rising edge):
  - If aluout[1:0] != 0: no RAM or register update, store_cnt does not increment, align_err <= 1.
  - Aligned RAM store: ram[index] <= writedata; store_cnt increments.
  - Aligned MMIO store to offset 0x0: led <= writedata; store_cnt increments.
  - Aligned MMIO stores to 0x4, 0x8, 0xC are ignored (read-only) but still increment store_cnt.
  - Pass check is on the full 32-bit address before aliasing: aligned store with aluout==DONE_ADDR and writedata==DONE_DATA sets done <= 1. done is sticky until reset.
  - A store to DONE_ADDR with any other data still writes RAM and does not clear done.
- Counters:
  - cycle_cnt increments by 1 every non-reset cycle and wraps 32'hFFFF_FFFF -> 0.
  - store_cnt is 32-bit and wraps the same way.
  - A store in the same cycle the cycle counter wraps has no interaction.
- pc input is not used for decode. It exists so the core port list matches one-to-one and may drive a debug probe.

Test Plan:
- Reset then idle 10 cycles -> led=0, done=0, align_err=0; read MMIO_BASE+4 returns 10 (±0 relative to the first post-reset edge); store_cnt=0.
- Store 0xDEADBEEF to address 0x10, then load 0x10 -> readdata=0xDEADBEEF on the following cycle. Same-cycle read shows the prior value. Load of 0x110 (alias, DEPTH_LOG2=6) also returns 0xDEADBEEF.
- Store 7 to address 84 -> done=1 next cycle. Then store 5 to 84 -> done stays 1, RAM[21]=5. Store 7 to 84+256 -> RAM[21]=7 but no new done event (assert by checking from reset in a separate run).
- Store 0x1234 to 0x13 -> align_err=1, RAM[4] unchanged, store_cnt unchanged. Subsequent aligned store -> store_cnt increments, align_err stays 1.
- Store 0xA5 to MMIO_BASE -> led=0xA5. Store to MMIO_BASE+4 -> cycle_cnt unaffected, store_cnt +1. Read MMIO_BASE+C after the misaligned test -> 32'h2 or 32'h3 per flags.
- Assert rst for one cycle mid-run with memwrite=1 to 0x20 -> RAM[8] not written, all counters and flags return to 0, RAM contents elsewhere preserved.

Source files
------------

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_if
// Brief    : Core-to-data-memory port bundle (address, store, load data).
// Revision : 1.0
// ============================================================================
interface data_mem_responder_if;
    logic [31:0] pc;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output pc,
        output memwrite,
        output aluout,
        output writedata,
        input  readdata
    );

    modport slave (
        input  pc,
        input  memwrite,
        input  aluout,
        input  writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Data RAM plus LED/cycle/store/status register page for the
//            single-cycle MIPS core, with pass-store and misalignment flags.
// Revision : 1.0
// ============================================================================
module data_mem_responder #(
    parameter int          DEPTH_LOG2 = 6,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00,
    parameter logic [31:0] DONE_ADDR  = 32'd84,
    parameter logic [31:0] DONE_DATA  = 32'd7
) (
    input  wire logic           clk,
    input  wire logic           rst,
    data_mem_responder_if.slave bus,
    output logic [31:0]         led,
    output logic                done,
    output logic                align_err
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] c_OFF_LED    = 2'd0;
    localparam logic [1:0] c_OFF_CYCLE  = 2'd1;
    localparam logic [1:0] c_OFF_STORES = 2'd2;

    logic [31:0] r_mem [0:c_DEPTH-1];
    logic [31:0] r_led;
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_store_cnt;
    logic        r_done;
    logic        r_align_err;

    logic [DEPTH_LOG2-1:0] w_index;
    logic [1:0]            w_offset;
    logic                  w_mmio_hit;
    logic                  w_aligned;
    logic                  w_store;
    logic                  w_pass_store;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    assign w_index      = bus.aluout[DEPTH_LOG2+1:2];
    assign w_offset     = bus.aluout[3:2];
    assign w_mmio_hit   = (bus.aluout[31:4] == MMIO_BASE[31:4]);
    assign w_aligned    = (bus.aluout[1:0] == 2'b00);
    assign w_store      = bus.memwrite && w_aligned;
    // Pass detection uses the full address, so aliases of DONE_ADDR do not count.
    assign w_pass_store = w_store && (bus.aluout == DONE_ADDR)
                                  && (bus.writedata == DONE_DATA);

    // pc is carried only so the port list mirrors the core.
    assign w_unused = ^bus.pc;

    // RAM has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && w_store && !w_mmio_hit) begin
            r_mem[w_index] <= bus.writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led       <= 32'd0;
            r_cycle_cnt <= 32'd0;
            r_store_cnt <= 32'd0;
            r_done      <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (bus.memwrite && !w_aligned) begin
                r_align_err <= 1'b1;
            end
            if (w_store) begin
                r_store_cnt <= r_store_cnt + 32'd1;
                if (w_mmio_hit && (w_offset == c_OFF_LED)) begin
                    r_led <= bus.writedata;
                end
            end
            if (w_pass_store) begin
                r_done <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rdata = r_mem[w_index];
        if (w_mmio_hit) begin
            case (w_offset)
                c_OFF_LED:    w_rdata = r_led;
                c_OFF_CYCLE:  w_rdata = r_cycle_cnt;
                c_OFF_STORES: w_rdata = r_store_cnt;
                default:      w_rdata = {30'd0, r_align_err, r_done};
            endcase
        end
    end

    assign bus.readdata = w_rdata;
    assign led          = r_led;
    assign done         = r_done;
    assign align_err    = r_align_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Self-checking bench for data_mem_responder against a word-level model.
// Revision : 1.0
// ============================================================================
module tb_data_mem_responder;

    localparam logic [31:0] c_MMIO = 32'hFFFF_FF00;
    localparam int          c_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] led;
    logic        done;
    logic        align_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_mem [c_WORDS];
    bit          m_known [c_WORDS];
    logic [31:0] m_led, m_cyc, m_stc;
    bit          m_done, m_aerr;

    always #5 clk = ~clk;

    data_mem_responder_if bus ();

    data_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .led       (led),
        .done      (done),
        .align_err (align_err)
    );

    function automatic bit is_mmio(input logic [31:0] a);
        return (a >= c_MMIO) && (a < c_MMIO + 32'd16);
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, output bit known);
        int idx;
        known = 1'b1;
        if (is_mmio(a)) begin
            case ((a - c_MMIO) / 4)
                0:       return m_led;
                1:       return m_cyc;
                2:       return m_stc;
                default: return {30'd0, m_aerr, m_done};
            endcase
        end
        idx   = int'((a / 4) % c_WORDS);
        known = m_known[idx];
        return m_mem[idx];
    endfunction

    task automatic drive(input bit mw, input logic [31:0] a, input logic [31:0] d);
        bus.memwrite  = mw;
        bus.aluout    = a;
        bus.writedata = d;
        bus.pc        = $urandom;
        #1;
    endtask

    task automatic tick();
        logic [31:0] a, d;
        @(posedge clk);
        a = bus.aluout;
        d = bus.writedata;
        if (rst) begin
            m_led = 0; m_cyc = 0; m_stc = 0; m_done = 0; m_aerr = 0;
        end else begin
            m_cyc = m_cyc + 1;
            if (bus.memwrite) begin
                if (a % 4 != 0) begin
                    m_aerr = 1;
                end else begin
                    m_stc = m_stc + 1;
                    if (is_mmio(a)) begin
                        if (a == c_MMIO) m_led = d;
                    end else begin
                        m_mem[(a / 4) % c_WORDS]   = d;
                        m_known[(a / 4) % c_WORDS] = 1'b1;
                    end
                    if (a == 32'd84 && d == 32'd7) m_done = 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        tick(); tick();
        rst = 1'b0;
        repeat (10) tick();
        n_checks++; if (led !== 32'd0) begin n_fail++; $display("FAIL reset_led: got %h want 0", led); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL reset_aerr: got %b want 0", align_err); end
        drive(1'b0, c_MMIO + 32'd4, 32'h0);
        n_checks++; if (bus.readdata !== 32'd10) begin n_fail++; $display("FAIL reset_cycle_cnt: got %0d want 10", bus.readdata); end
        drive(1'b0, c_MMIO + 32'd8, 32'h0);
        n_checks++; if (bus.readdata !== 32'd0) begin n_fail++; $display("FAIL reset_store_cnt: got %0d want 0", bus.readdata); end
    endtask

    task automatic test_ram();
        drive(1'b1, 32'h10, 32'hDEAD_BEEF); tick();
        drive(1'b0, 32'h10, 32'h0);
        n_checks++; if (bus.readdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_read: got %h want deadbeef", bus.readdata); end
        drive(1'b0, 32'h110, 32'h0);
        n_checks++; if (bus.readdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_alias: got %h want deadbeef", bus.readdata); end
        drive(1'b1, 32'h10, 32'hCAFE_F00D);
        n_checks++; if (bus.readdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_rdw_old: got %h want deadbeef", bus.readdata); end
        tick();
        drive(1'b0, 32'h10, 32'h0);
        n_checks++; if (bus.readdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL ram_rdw_new: got %h want cafef00d", bus.readdata); end
        drive(1'b1, 32'h20, 32'h1111_1111); tick();
        drive(1'b0, c_MMIO + 32'd8, 32'h0);
        n_checks++; if (bus.readdata !== 32'd3) begin n_fail++; $display("FAIL ram_store_cnt: got %0d want 3", bus.readdata); end
    endtask

    task automatic test_done();
        rst = 1'b1; drive(1'b0, 32'h0, 32'h0); tick(); rst = 1'b0;
        drive(1'b1, 32'd340, 32'd7); tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_alias: got %b want 0", done); end
        drive(1'b0, 32'd84, 32'h0);
        n_checks++; if (bus.readdata !== 32'd7) begin n_fail++; $display("FAIL done_alias_ram: got %h want 7", bus.readdata); end
        drive(1'b1, 32'd84, 32'd7); tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_set: got %b want 1", done); end
        drive(1'b1, 32'd84, 32'd5); tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_sticky: got %b want 1", done); end
        drive(1'b0, 32'd84, 32'h0);
        n_checks++; if (bus.readdata !== 32'd5) begin n_fail++; $display("FAIL done_ram21: got %h want 5", bus.readdata); end
    endtask

    task automatic test_misaligned();
        logic [31:0] stc0;
        stc0 = m_stc;
        drive(1'b1, 32'h13, 32'h1234); tick();
        n_checks++; if (align_err !== 1'b1) begin n_fail++; $display("FAIL misalign_flag: got %b want 1", align_err); end
        drive(1'b0, 32'h10, 32'h0);
        n_checks++; if (bus.readdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL misalign_ram: got %h want cafef00d", bus.readdata); end
        drive(1'b0, c_MMIO + 32'd8, 32'h0);
        n_checks++; if (bus.readdata !== stc0) begin n_fail++; $display("FAIL misalign_stc: got %0d want %0d", bus.readdata, stc0); end
        drive(1'b1, 32'h30, 32'h55); tick();
        drive(1'b0, c_MMIO + 32'd8, 32'h0);
        n_checks++; if (bus.readdata !== stc0 + 32'd1) begin n_fail++; $display("FAIL misalign_stc_inc: got %0d want %0d", bus.readdata, stc0 + 32'd1); end
        n_checks++; if (align_err !== 1'b1) begin n_fail++; $display("FAIL misalign_sticky: got %b want 1", align_err); end
    endtask

    task automatic test_mmio();
        logic [31:0] c0, s0;
        drive(1'b1, c_MMIO, 32'hA5); tick();
        n_checks++; if (led !== 32'hA5) begin n_fail++; $display("FAIL mmio_led: got %h want a5", led); end
        drive(1'b0, c_MMIO, 32'h0);
        n_checks++; if (bus.readdata !== 32'hA5) begin n_fail++; $display("FAIL mmio_led_rd: got %h want a5", bus.readdata); end
        drive(1'b0, c_MMIO + 32'd4, 32'h0);
        c0 = bus.readdata;
        s0 = m_stc;
        tick();
        drive(1'b1, c_MMIO + 32'd4, 32'hFFFF_0000); tick();
        drive(1'b0, c_MMIO + 32'd4, 32'h0);
        n_checks++; if (bus.readdata !== c0 + 32'd2) begin n_fail++; $display("FAIL mmio_cyc_ro: got %0d want %0d", bus.readdata, c0 + 32'd2); end
        drive(1'b0, c_MMIO + 32'd8, 32'h0);
        n_checks++; if (bus.readdata !== s0 + 32'd1) begin n_fail++; $display("FAIL mmio_stc: got %0d want %0d", bus.readdata, s0 + 32'd1); end
        drive(1'b0, c_MMIO + 32'hC, 32'h0);
        n_checks++; if (bus.readdata !== 32'h3) begin n_fail++; $display("FAIL mmio_status: got %h want 3", bus.readdata); end
    endtask

    task automatic test_reset_midrun();
        rst = 1'b1;
        drive(1'b1, 32'h20, 32'h0000_0BAD); tick();
        rst = 1'b0;
        drive(1'b0, 32'h20, 32'h0);
        n_checks++; if (bus.readdata !== 32'h1111_1111) begin n_fail++; $display("FAIL midrst_ram8: got %h want 11111111", bus.readdata); end
        drive(1'b0, 32'h10, 32'h0);
        n_checks++; if (bus.readdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL midrst_ram4: got %h want cafef00d", bus.readdata); end
        n_checks++; if ({led, done, align_err} !== 34'd0) begin n_fail++; $display("FAIL midrst_regs: got led=%h done=%b aerr=%b want 0", led, done, align_err); end
        drive(1'b0, c_MMIO + 32'd4, 32'h0);
        n_checks++; if (bus.readdata !== 32'd0) begin n_fail++; $display("FAIL midrst_cyc: got %0d want 0", bus.readdata); end
        drive(1'b0, c_MMIO + 32'd8, 32'h0);
        n_checks++; if (bus.readdata !== 32'd0) begin n_fail++; $display("FAIL midrst_stc: got %0d want 0", bus.readdata); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, exp;
        bit known;
        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2: a = {$urandom_range(0, 255), 2'b00};
                3:       a = {$urandom} & 32'hFFFF_FFFC;
                4:       a = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(1, 3));
                5, 6:    a = c_MMIO + 32'($urandom_range(0, 3) * 4);
                7:       begin a = 32'd84; if ($urandom_range(0, 1) == 1) d = 32'd7; end
                default: a = 32'd84 + 32'($urandom_range(1, 7) * 256);
            endcase
            rst = ($urandom_range(0, 49) == 0);
            drive(1'($urandom_range(0, 1)), a, d);
            exp = exp_read(a, known);
            if (known) begin
                n_checks++;
                if (bus.readdata !== exp) begin n_fail++; $display("FAIL rand_read[%0d] addr %h: got %h want %h", i, a, bus.readdata, exp); end
            end
            tick();
            n_checks++;
            if ({led, done, align_err} !== {m_led, m_done, m_aerr}) begin
                n_fail++;
                $display("FAIL rand_regs[%0d]: got led=%h done=%b aerr=%b want led=%h done=%b aerr=%b",
                         i, led, done, align_err, m_led, m_done, m_aerr);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < c_WORDS; i++) m_known[i] = 1'b0;
        m_led = 0; m_cyc = 0; m_stc = 0; m_done = 0; m_aerr = 0;
        rst = 1'b1;
        bus.memwrite = 1'b0; bus.aluout = 32'h0; bus.writedata = 32'h0; bus.pc = 32'h0;
        test_reset();
        test_ram();
        test_done();
        test_misaligned();
        test_mmio();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
